// File: rtl/io_sync_blink_pkg.sv
// Shared defaults for the Z180 bus front-end conditioning block.
package io_sync_blink_pkg;

    localparam int STAGES_DEFAULT  = 2;
    localparam int PHI_DIV_DEFAULT = 24;
    localparam int CLK_DIV_DEFAULT = 26;

endpackage

// File: rtl/io_sync_blink_sync_chain.sv
// Plain flop chain synchroniser; nothing sits between the stages.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/io_sync_blink.sv
// Synchronises Z180 strobes and PHI into i_clk, emits PHI edge pulses
// and two free-running blink waveforms.
module io_sync_blink
    import io_sync_blink_pkg::*;
#(
    parameter int STAGES  = STAGES_DEFAULT,
    parameter int PHI_DIV = PHI_DIV_DEFAULT,
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phi,
    input  logic i_iorq_n,
    input  logic i_rd_n,
    input  logic i_wr_n,
    output logic o_io_read,
    output logic o_io_write,
    output logic o_phi,
    output logic o_phi_edge,
    output logic o_blink1,
    output logic o_blink2
);

    logic io_read_raw;
    logic io_write_raw;

    // Decode before the chains so each strobe crosses as a single bit.
    assign io_read_raw  = ~i_iorq_n & ~i_rd_n;
    assign io_write_raw = ~i_iorq_n & ~i_wr_n;

    sync_chain #(.STAGES(STAGES)) u_sync_read (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (io_read_raw),
        .o_q   (o_io_read)
    );

    sync_chain #(.STAGES(STAGES)) u_sync_write (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (io_write_raw),
        .o_q   (o_io_write)
    );

    sync_chain #(.STAGES(STAGES)) u_sync_phi (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_phi),
        .o_q   (o_phi)
    );

    logic               phi_prev_q;
    logic               phi_prev_d;
    logic [PHI_DIV-1:0] phi_cnt_q;
    logic [PHI_DIV-1:0] phi_cnt_d;
    logic [CLK_DIV-1:0] clk_cnt_q;
    logic [CLK_DIV-1:0] clk_cnt_d;

    assign o_phi_edge = o_phi & ~phi_prev_q;

    always_comb begin
        phi_prev_d = o_phi;
        phi_cnt_d  = phi_cnt_q + PHI_DIV'(o_phi_edge);
        clk_cnt_d  = clk_cnt_q + CLK_DIV'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phi_prev_q <= 1'b0;
            phi_cnt_q  <= '0;
            clk_cnt_q  <= '0;
        end else begin
            phi_prev_q <= phi_prev_d;
            phi_cnt_q  <= phi_cnt_d;
            clk_cnt_q  <= clk_cnt_d;
        end
    end

    assign o_blink1 = phi_cnt_q[PHI_DIV-1];
    assign o_blink2 = clk_cnt_q[CLK_DIV-1];

endmodule

// File: tb/tb_io_sync_blink.sv
// Randomised bench for io_sync_blink against a cycle-history reference model.
module tb_io_sync_blink;

    localparam int S  = 2;
    localparam int PD = 4;
    localparam int CD = 3;

    logic clk = 1'b0;
    logic rst;
    logic phi, iorq_n, rd_n, wr_n;
    logic io_read, io_write, phi_s, phi_edge, blink1, blink2;

    always #5 clk = ~clk;

    io_sync_blink #(
        .STAGES  (S),
        .PHI_DIV (PD),
        .CLK_DIV (CD)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_phi      (phi),
        .i_iorq_n   (iorq_n),
        .i_rd_n     (rd_n),
        .i_wr_n     (wr_n),
        .o_io_read  (io_read),
        .o_io_write (io_write),
        .o_phi      (phi_s),
        .o_phi_edge (phi_edge),
        .o_blink1   (blink1),
        .o_blink2   (blink2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model: each output is the input sampled S clock edges ago (zeros
    // after reset); counts are plain integers since reset release.
    bit q_rd[$];
    bit q_wr[$];
    bit q_phi[$];
    int m_edges  = 0;
    int m_cycles = 0;
    bit armed    = 0;

    function automatic bit m_at(input bit q[$], input int k);
        return (q.size() > k) ? q[k] : 1'b0;
    endfunction

    function automatic bit m_edge();
        return m_at(q_phi, S-1) && !m_at(q_phi, S);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_rd  = {};
            q_wr  = {};
            q_phi = {};
            m_edges  = 0;
            m_cycles = 0;
            armed    = 1;
        end else begin
            if (m_edge()) m_edges++;
            m_cycles++;
            q_rd.push_front(!iorq_n && !rd_n);
            q_wr.push_front(!iorq_n && !wr_n);
            q_phi.push_front(phi);
            while (q_rd.size() > S)    void'(q_rd.pop_back());
            while (q_wr.size() > S)    void'(q_wr.pop_back());
            while (q_phi.size() > S+1) void'(q_phi.pop_back());
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("io_read",  io_read,  m_at(q_rd, S-1));
            check("io_write", io_write, m_at(q_wr, S-1));
            check("phi",      phi_s,    m_at(q_phi, S-1));
            check("phi_edge", phi_edge, m_edge());
            check("blink1",   blink1,   int'((m_edges % 16) >= 8));
            check("blink2",   blink2,   int'((m_cycles % 8) >= 4));
        end
    end

    int pulses;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; phi = 1; iorq_n = 1; rd_n = 1; wr_n = 1;
        cyc(3);
        rst = 0;
        cyc(6);

        // Directed strobes, changed right after a negedge.
        phi = 0;
        iorq_n = 0; rd_n = 0; cyc(5);
        iorq_n = 1; rd_n = 1; cyc(5);
        iorq_n = 0; wr_n = 0; cyc(5);
        iorq_n = 1; wr_n = 1; cyc(5);

        // Square PHI: 3 high / 3 low, 10 periods.
        pulses = 0;
        for (int p = 0; p < 10; p++) begin
            phi = 1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1 pulses += int'(phi_edge);
            end
            phi = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1 pulses += int'(phi_edge);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1 pulses += int'(phi_edge);
        end
        check("phi_pulses", pulses, 10);

        // Random PHI phases (>=2 cycles) with random strobes.
        for (int seg = 0; seg < 60; seg++) begin
            phi = ~phi;
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                iorq_n = 1'($urandom);
                rd_n   = 1'($urandom);
                wr_n   = 1'($urandom);
                @(negedge clk);
            end
        end

        // Reset while blink2 is high and PHI keeps toggling.
        for (int k = 0; k < 16 && !((m_cycles % 8) >= 4); k++) begin
            phi = ~phi;
            @(negedge clk);
        end
        #1 check("blink2_pre_rst", blink2, 1);
        phi = ~phi;
        rst = 1;
        @(negedge clk);
        #1 check("edge_in_rst", phi_edge, 0);
        check("blink1_in_rst", blink1, 0);
        check("blink2_in_rst", blink2, 0);
        rst = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) phi = ~phi;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
